// File: rtl/sec_scrub_ctrl.sv
// Background memory scrubber: walks every word and, when the corrector
// reports a single-bit fix, writes the corrected word back.
module sec_scrub_ctrl #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AW       = 8,
  parameter int unsigned INTERVAL = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [39:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic [39:0]   mem_rdata,
  output logic [31:0]   dec_data,
  output logic [7:0]    dec_chk,
  output logic          dec_en,
  input  logic [31:0]   dec_corr,
  output logic          busy,
  output logic [15:0]   err_count,
  output logic [AW-1:0] last_err_addr,
  output logic          pass_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_NEXT = 3'd6;

  localparam int unsigned TW           = 16;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(INTERVAL - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [15:0]   ERR_MAX    = 16'hFFFF;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   raw_data_q, raw_data_d;
  logic [7:0]    raw_chk_q, raw_chk_d;
  logic [31:0]   corr_data_q, corr_data_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [AW-1:0] last_err_addr_q, last_err_addr_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [39:0]   mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          pass_done_q, pass_done_d;

  // Next-state, datapath updates and registered-output look-ahead
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    addr_d          = addr_q;
    raw_data_d      = raw_data_q;
    raw_chk_d       = raw_chk_q;
    corr_data_d     = corr_data_q;
    err_count_d     = err_count_q;
    last_err_addr_d = last_err_addr_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          timer_d = TIMER_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_RD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RD: begin
        if (mem_gnt) state_d = S_CAP;
      end
      S_CAP: begin
        raw_data_d = mem_rdata[31:0];
        raw_chk_d  = mem_rdata[39:32];
        state_d    = S_CHK;
      end
      S_CHK: begin
        if (dec_corr != raw_data_q) begin
          corr_data_d     = dec_corr;
          last_err_addr_d = addr_q;
          if (err_count_q != ERR_MAX) err_count_d = err_count_q + 16'd1;
          state_d = S_WR;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR: begin
        if (mem_gnt) state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d = addr_q + AW'(1);
        if (en) begin
          timer_d = TIMER_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it
    mem_req_d   = (state_d == S_RD) || (state_d == S_WR);
    mem_we_d    = (state_d == S_WR);
    mem_wdata_d = (state_d == S_WR) ? {raw_chk_d, corr_data_d} : 40'd0;
    busy_d      = (state_d != S_IDLE);
    // addr_q still holds the finishing word's address when NEXT is entered
    pass_done_d = (state_d == S_NEXT) && (addr_q == LAST_ADDR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      addr_q          <= '0;
      raw_data_q      <= '0;
      raw_chk_q       <= '0;
      corr_data_q     <= '0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      pass_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      addr_q          <= addr_d;
      raw_data_q      <= raw_data_d;
      raw_chk_q       <= raw_chk_d;
      corr_data_q     <= corr_data_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      pass_done_q     <= pass_done_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign dec_data      = raw_data_q;
  assign dec_chk       = raw_chk_q;
  assign dec_en        = 1'b1;
  assign busy          = busy_q;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;
  assign pass_done     = pass_done_q;

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// Directed bench for sec_scrub_ctrl: 4-word memory, 4-cycle interval, toy SEC corrector.
module tb_sec_scrub_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [39:0] mem_wdata;
  logic        mem_gnt;
  logic [39:0] mem_rdata;
  logic [31:0] dec_data;
  logic [7:0]  dec_chk;
  logic        dec_en;
  logic [31:0] dec_corr;
  logic        busy;
  logic [15:0] err_count;
  logic [1:0]  last_err_addr;
  logic        pass_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [39:0] mem [4];
  logic [31:0] orig [4];
  logic [1:0]  rd_addr_q [$];
  logic [1:0]  wr_addr_q [$];
  logic [39:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          rd_cyc_a  [4];

  sec_scrub_ctrl #(.DEPTH(4), .AW(2), .INTERVAL(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .dec_data(dec_data), .dec_chk(dec_chk), .dec_en(dec_en), .dec_corr(dec_corr),
    .busy(busy), .err_count(err_count), .last_err_addr(last_err_addr), .pass_done(pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check bits: xor of (bit position + 1) over all set data bits
  function automatic logic [7:0] calc_chk(input logic [31:0] d);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < 32; i++) if (d[i]) c = c ^ 8'(i + 1);
    return c;
  endfunction

  // Single-error corrector: nonzero syndrome names the flipped bit
  function automatic logic [31:0] sec_fix(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  s;
    logic [31:0] r;
    r = d;
    s = calc_chk(d) ^ c;
    if (s != 8'd0 && s <= 8'd32) r[int'(s) - 1] = ~r[int'(s) - 1];
    return r;
  endfunction

  assign dec_corr = sec_fix(dec_data, dec_chk);

  // Memory model: read data returned the cycle after a read grant
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc);
        mem[mem_addr] = mem_wdata;
      end else begin
        rd_addr_q.push_back(mem_addr);
        rd_cyc_a[mem_addr] = cyc;
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  int n;

  initial begin
    orig[0] = 32'h0000_1234;
    orig[1] = 32'hDEAD_BEEF;
    orig[2] = 32'h1357_9BDF;
    orig[3] = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      mem[i] = {calc_chk(orig[i]), orig[i]};
      rd_cyc_a[i] = 0;
    end
    mem_rdata = 40'd0;
    rst = 1'b1;
    en = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req", 64'(mem_req), 64'(0));
    check("rst_dec_en", 64'(dec_en), 64'(1));
    check("rst_errcnt", 64'(err_count), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_dec_data", 64'(dec_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    // Clean pass: first read after IDLE + 4 wait cycles
    en = 1'b1;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_rd_latency", 64'(n), 64'(5));
    check("first_rd_addr", 64'(mem_addr), 64'(0));
    n = 0;
    while (!pass_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("p1_pass_done", 64'(pass_done), 64'(1));
    check("p1_nrd", 64'(rd_addr_q.size()), 64'(4));
    for (int i = 0; i < rd_addr_q.size(); i++) check("p1_rd_addr", 64'(rd_addr_q[i]), 64'(i));
    check("p1_nwr", 64'(wr_addr_q.size()), 64'(0));
    check("p1_errcnt", 64'(err_count), 64'(0));
    en = 1'b0;
    @(negedge clk);
    check("p1_pulse_once", 64'(pass_done), 64'(0));
    check("p1_idle", 64'(busy), 64'(0));
    check("p1_addr_wrap", 64'(mem_addr), 64'(0));

    // Bit 5 flipped in word 2: one write-back of the original word
    mem[2] = {calc_chk(orig[2]), orig[2] ^ 32'h0000_0020};
    clear_log();
    en = 1'b1;
    n = 0;
    while (!pass_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("p2_pass_done", 64'(pass_done), 64'(1));
    check("p2_nwr", 64'(wr_addr_q.size()), 64'(1));
    if (wr_addr_q.size() > 0) begin
      check("p2_wr_addr", 64'(wr_addr_q[0]), 64'(2));
      check("p2_wr_data", 64'(wr_data_q[0]), 64'({calc_chk(orig[2]), orig[2]}));
      check("p2_latency", 64'(wr_cyc_q[0] - rd_cyc_a[2]), 64'(3));
    end
    check("p2_errcnt", 64'(err_count), 64'(1));
    check("p2_last_err", 64'(last_err_addr), 64'(2));
    en = 1'b0;
    @(negedge clk);

    // Grant withheld for 10 cycles in RD
    mem_gnt = 1'b0;
    en = 1'b1;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("gnt_rd_seen", 64'(mem_req), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gnt_hold", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 2'd0}));
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check("gnt_cap_req", 64'(mem_req), 64'(0));
    check("gnt_cap_busy", 64'(busy), 64'(1));
    @(negedge clk);
    check("gnt_chk_data", 64'(dec_data), 64'(orig[0]));
    check("gnt_chk_chk", 64'(dec_chk), 64'(calc_chk(orig[0])));
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("gnt_idle", 64'(busy), 64'(0));
    check("gnt_addr", 64'(mem_addr), 64'(1));

    // en dropped in CHK with an error pending
    mem[1] = {calc_chk(orig[1]), orig[1] ^ 32'h0000_0080};
    clear_log();
    en = 1'b1;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drop_rd_addr", 64'(mem_addr), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check("drop_chk_req", 64'(mem_req), 64'(0));
    en = 1'b0;
    @(negedge clk);
    check("drop_wr_req", 64'({mem_req, mem_we}), 64'(2'b11));
    check("drop_wr_data", 64'(mem_wdata), 64'({calc_chk(orig[1]), orig[1]}));
    @(negedge clk);
    check("drop_next_req", 64'(mem_req), 64'(0));
    check("drop_next_wdata", 64'(mem_wdata), 64'(0));
    @(negedge clk);
    check("drop_idle", 64'(busy), 64'(0));
    check("drop_addr", 64'(mem_addr), 64'(2));
    check("drop_errcnt", 64'(err_count), 64'(2));
    check("drop_last_err", 64'(last_err_addr), 64'(1));
    check("drop_nwr", 64'(wr_addr_q.size()), 64'(1));

    // Saturated error counter still writes back and records the address
    force dut.err_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.err_count_q;
    @(negedge clk);
    check("sat_preset", 64'(err_count), 64'(16'hFFFF));
    mem[2] = {calc_chk(orig[2]), orig[2] ^ 32'h0000_0001};
    clear_log();
    en = 1'b1;
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sat_wr_seen", 64'({mem_req, mem_we}), 64'(2'b11));
    check("sat_wr_addr", 64'(mem_addr), 64'(2));
    en = 1'b0;
    @(negedge clk);
    check("sat_errcnt", 64'(err_count), 64'(16'hFFFF));
    check("sat_last_err", 64'(last_err_addr), 64'(2));
    @(negedge clk);
    check("sat_nwr", 64'(wr_addr_q.size()), 64'(1));
    check("sat_mem_fixed", 64'(mem[2]), 64'({calc_chk(orig[2]), orig[2]}));

    // Reset asserted while the write-back is pending
    mem[3] = {calc_chk(orig[3]), orig[3] ^ 32'h8000_0000};
    clear_log();
    en = 1'b1;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wrst_rd_addr", 64'(mem_addr), 64'(3));
    @(negedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    check("wrst_in_wr", 64'({mem_req, mem_we}), 64'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    check("wrst_req", 64'(mem_req), 64'(0));
    check("wrst_errcnt", 64'(err_count), 64'(0));
    check("wrst_busy", 64'(busy), 64'(0));
    check("wrst_addr", 64'(mem_addr), 64'(0));
    check("wrst_last_err", 64'(last_err_addr), 64'(0));
    check("wrst_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;
    en = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("wrst_nwr", 64'(wr_addr_q.size()), 64'(0));
    check("wrst_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sec_scrub_ctrl.md
SEC_SCRUB_CTRL -- requirements
Module: sec_scrub_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, number of 40-bit memory words scrubbed per pass (power of two, 2..65536).
REQ-002 The block SHALL have parameter AW, default 8, address width, equal to log2(DEPTH).
REQ-003 The block SHALL have parameter INTERVAL, default 1024, idle cycles between word scrubs (1..65535).
REQ-004 Ports SHALL be as follows; one clock, with a synchronous active-high reset:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  scrub enable
- mem_req  out  1  memory access request
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_addr  out  AW  word address
- mem_wdata  out  40  {chk[7:0], data[31:0]}
- mem_gnt  in  1  access accepted this cycle; the host has priority
- mem_rdata  in  40  read word; valid the cycle after a read grant
- dec_data  out  32  raw data to the SEC corrector
- dec_chk  out  8  raw check bits to the SEC corrector
- dec_en  out  1  corrector enable (check-bit gating input)
- dec_corr  in  32  corrected data from the corrector (combinational)
- busy  out  1  high in any state except IDLE
- err_count  out  16  corrected-word count, saturating
- last_err_addr  out  AW  address of the most recent corrected word
- pass_done  out  1  one-cycle pulse at the end of each full pass

Function
REQ-005 The FSM SHALL have states IDLE, WAIT, RD, CAP, CHK, WR and NEXT, with one state register.
REQ-006 In IDLE with en=1, the FSM SHALL load timer=INTERVAL-1 and go to WAIT; with en=0 it SHALL stay in IDLE.
REQ-007 In WAIT, the timer SHALL decrement each cycle; the FSM SHALL go to RD in the cycle after the timer reads 0.
REQ-008 In RD, the block SHALL drive mem_req=1, mem_we=0 and mem_addr=addr, and SHALL hold them until a cycle with mem_gnt=1, then go to CAP.
REQ-009 In CAP, the block SHALL register mem_rdata[31:0] into raw_data and mem_rdata[39:32] into raw_chk, then go to CHK.
REQ-010 dec_data SHALL equal raw_data, dec_chk SHALL equal raw_chk, and dec_en SHALL be 1, at all times.
REQ-011 In CHK, if dec_corr != raw_data, the block SHALL register dec_corr into corr_data, increment err_count (saturating at 16'hFFFF), load last_err_addr=addr, and go to WR; otherwise it SHALL go to NEXT with no counter change.
REQ-012 In WR, the block SHALL drive mem_req=1, mem_we=1, mem_addr=addr and mem_wdata={raw_chk, corr_data}, and SHALL hold them until mem_gnt=1, then go to NEXT.
REQ-013 In NEXT, addr SHALL increment modulo DEPTH; if the old addr was DEPTH-1, pass_done SHALL be 1 for exactly that cycle.
REQ-014 From NEXT, the FSM SHALL go to WAIT (timer reloaded to INTERVAL-1) if en=1, else to IDLE; addr SHALL be retained across IDLE.
REQ-015 A deassertion of en in WAIT SHALL return the FSM to IDLE in the next cycle with no access issued.
REQ-016 A deassertion of en in RD, CAP, CHK or WR SHALL NOT abort the word; the FSM SHALL finish through NEXT and then go to IDLE.
REQ-017 mem_req SHALL be 0 in every state except RD and WR; mem_wdata SHALL be 0 when not in WR.
REQ-018 With err_count already at 16'hFFFF, a further correction SHALL still update last_err_addr and perform the write-back.
REQ-019 Latency from RD grant to write-back request SHALL be exactly 3 cycles (CAP, CHK, WR).

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE, addr=0, timer=0, err_count=0, last_err_addr=0, raw_data=0, raw_chk=0 and corr_data=0, in any state.
REQ-021 During and after reset, all outputs SHALL be 0 except dec_en=1 and dec_corr-derived values; a reset during WR SHALL drop mem_req in the next cycle with no write completed.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- INTERVAL=4, DEPTH=4, clean memory, en=1, mem_gnt=1 always -> reads at addr 0,1,2,3, no write, pass_done after addr 3, err_count=0.
- Word 2 stored with data bit 5 flipped -> one write at addr 2 with the original data and stored chk, err_count=1, last_err_addr=2.
- mem_gnt held 0 for 10 cycles in RD -> mem_req/addr stable for 10 cycles, CAP on the cycle after the grant.
- en dropped in CHK with an error present -> write-back completes, FSM goes to IDLE, busy=0, addr advanced by 1.
- err_count preset to 16'hFFFF via 65535 injected errors (or forced) plus one more error -> err_count stays FFFF, last_err_addr updated.
- rst asserted in WR -> next cycle mem_req=0, err_count=0, state IDLE.
